dct_row_mac_sequencer: RTL and testbench

- Sits around the 8x64 dual-address coefficient ROM (two read ports, 2-cycle registered read latency, no reset, no stall).
- Accepts one 8-sample vector, drives both ROM address ports through all 8 coefficient rows (two rows per cycle), consumes the returned rows, and emits 8 signed dot products as 4 result pairs.
- Acts as both the address source that feeds the ROM and the consumer of its data outputs.

---
 rtl/dct_row_mac_sequencer.sv | 164 ++++++++++++++++
 tb/tb_dct_row_mac_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dct_row_mac_sequencer.sv
// Row-pair sequencer for the 8x64 dual-port coefficient ROM: latches one sample vector,
// walks both ROM ports through all 8 rows and emits the 8 signed dot products as 4 pairs.
module dct_row_mac_sequencer #(
    parameter int SAMPLE_W = 8,
    parameter int ACC_W    = 19,
    parameter int ROM_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*SAMPLE_W-1:0] sample_in,
    output logic [2:0]            rom_addr1,
    output logic [2:0]            rom_addr2,
    input  logic [8*SAMPLE_W-1:0] rom_dout1,
    input  logic [8*SAMPLE_W-1:0] rom_dout2,
    output logic                  out_valid,
    output logic [1:0]            out_idx,
    output logic [ACC_W-1:0]      out_y0,
    output logic [ACC_W-1:0]      out_y1,
    output logic                  out_last,
    output logic                  busy
);
    localparam int N      = 8;
    localparam int VEC_W  = N * SAMPLE_W;
    localparam int PROD_W = 2 * SAMPLE_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;
    logic [VEC_W-1:0]          x_q, x_d;
    logic [ROM_LAT-1:0]        pipe_vld_q, pipe_vld_d;
    logic [ROM_LAT-1:0][1:0]   pipe_idx_q, pipe_idx_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [1:0]                out_idx_q, out_idx_d;
    logic signed [ACC_W-1:0]   out_y0_q, out_y0_d;
    logic signed [ACC_W-1:0]   out_y1_q, out_y1_d;
    logic signed [ACC_W-1:0]   sum0, sum1;
    logic signed [PROD_W-1:0]  prod0, prod1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ISSUE;
                    cnt_d   = 2'd0;
                    x_d     = sample_in;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign rom_addr1 = (state_q == ISSUE) ? {cnt_q, 1'b0} : 3'd0;
    assign rom_addr2 = (state_q == ISSUE) ? {cnt_q, 1'b1} : 3'd0;

    // Tag travelling alongside each issue so only data with a matching tag is consumed.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_idx_d    = pipe_idx_q;
        pipe_vld_d[0] = (state_q == ISSUE);
        pipe_idx_d[0] = cnt_q;
        for (int j = 1; j < ROM_LAT; j++) begin
            pipe_vld_d[j] = pipe_vld_q[j-1];
            pipe_idx_d[j] = pipe_idx_q[j-1];
        end
    end

    always_comb begin
        sum0  = '0;
        sum1  = '0;
        prod0 = '0;
        prod1 = '0;
        for (int k = 0; k < N; k++) begin
            prod0 = $signed(rom_dout1[k*SAMPLE_W +: SAMPLE_W]) * $signed(x_q[k*SAMPLE_W +: SAMPLE_W]);
            prod1 = $signed(rom_dout2[k*SAMPLE_W +: SAMPLE_W]) * $signed(x_q[k*SAMPLE_W +: SAMPLE_W]);
            sum0  = sum0 + {{(ACC_W-PROD_W){prod0[PROD_W-1]}}, prod0};
            sum1  = sum1 + {{(ACC_W-PROD_W){prod1[PROD_W-1]}}, prod1};
        end
    end

    always_comb begin
        out_valid_d = pipe_vld_q[ROM_LAT-1];
        out_last_d  = pipe_vld_q[ROM_LAT-1] && (pipe_idx_q[ROM_LAT-1] == 2'd3);
        out_idx_d   = out_idx_q;
        out_y0_d    = out_y0_q;
        out_y1_d    = out_y1_q;
        if (pipe_vld_q[ROM_LAT-1]) begin
            out_idx_d = pipe_idx_q[ROM_LAT-1];
            out_y0_d  = sum0;
            out_y1_d  = sum1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= 2'd0;
            out_y0_q    <= '0;
            out_y1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_idx_q  <= pipe_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_y0_q    <= out_y0_d;
            out_y1_q    <= out_y1_d;
        end
    end

    // NOTE: the sample register is pure datapath, written before every use, so it carries no reset.
    always_ff @(posedge clk) begin
        x_q <= x_d;
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_y0    = out_y0_q;
    assign out_y1    = out_y1_q;

endmodule

// File: tb/tb_dct_row_mac_sequencer.sv
// Directed bench for dct_row_mac_sequencer with a 2-cycle registered ROM model
// and a table of sample vectors with hand-computed dot products.
module tb_dct_row_mac_sequencer;
    localparam int ACC_W = 19;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      sample_in;
    logic [2:0]       rom_addr1, rom_addr2;
    logic [63:0]      rom_dout1 = 64'hA5C3_5A3C_96E1_7F80;
    logic [63:0]      rom_dout2 = 64'h80F1_2233_C4D5_E6F7;
    logic             out_valid;
    logic [1:0]       out_idx;
    logic [ACC_W-1:0] out_y0, out_y1;
    logic             out_last;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int last_y0  = 0;
    int last_y1  = 0;

    typedef struct {
        logic [63:0] x;
        int          y [8];
    } vec_t;
    vec_t tbl [5];

    // Coefficient table; each row is listed as byte 0 .. byte 7.
    int coef [8][8] = '{
        '{  91,   91,   91,   91,   91,   91,   91,   91},
        '{-126, -106,  -71,  -25,   25,   71,  106,  -82},
        '{ 118,   49,  -49, -118, -118,  -49,   49,  118},
        '{-106,   25,  126,   71,  -71, -126,  -25,  106},
        '{  91,  -91,  -91,   91,   91,  -91,  -91,   91},
        '{ -71,  126,  -25, -106,  106,   25, -126,   71},
        '{  49, -118,  118,  -49,  -49,  118, -118,   49},
        '{ -25,   71, -106,  126, -126,  106,  -71,   25}
    };
    logic [63:0] rom [8];
    logic [2:0]  a1_q = 3'd5;
    logic [2:0]  a2_q = 3'd2;

    always #5 clk = ~clk;

    // ROM model: registered address then registered data, no reset.
    always @(posedge clk) begin
        a1_q      <= rom_addr1;
        a2_q      <= rom_addr2;
        rom_dout1 <= rom[a1_q];
        rom_dout2 <= rom[a2_q];
    end

    dct_row_mac_sequencer #(.SAMPLE_W(8), .ACC_W(ACC_W), .ROM_LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sample_in (sample_in),
        .rom_addr1 (rom_addr1),
        .rom_addr2 (rom_addr2),
        .rom_dout1 (rom_dout1),
        .rom_dout2 (rom_dout2),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_y0    (out_y0),
        .out_y1    (out_y1),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Check all outputs in cycle T+k of vector v (k = 1 is the first cycle after the accept).
    task automatic check_cycle(input int v, input int k);
        bit    ev  = (k >= 4 && k <= 7);
        int    idx = k - 4;
        string tag = $sformatf("v%0d k%0d", v, k);
        if (ev) begin
            last_y0 = tbl[v].y[2*idx];
            last_y1 = tbl[v].y[2*idx+1];
        end
        check({tag, " out_valid"}, out_valid, ev);
        check({tag, " out_last"}, out_last, (k == 7));
        check({tag, " out_y0"}, $signed(out_y0), last_y0);
        check({tag, " out_y1"}, $signed(out_y1), last_y1);
        check({tag, " in_ready"}, in_ready, (k >= 8));
        check({tag, " busy"}, busy, (k < 8));
        check({tag, " rom_addr1"}, rom_addr1, (k >= 1 && k <= 4) ? 2*(k-1) : 0);
        check({tag, " rom_addr2"}, rom_addr2, (k >= 1 && k <= 4) ? 2*(k-1)+1 : 0);
        if (ev) check({tag, " out_idx"}, out_idx, idx);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready wait", in_ready, 1);
    endtask

    // mode 0: plain vector; 1: in_valid pulse while busy; 2: reset asserted in T+5.
    task automatic run_vector(input int v, input int mode);
        wait_ready();
        in_valid  = 1'b1;
        sample_in = tbl[v].x;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid  = 1'b0;
                sample_in = ~tbl[v].x;
            end
            if (mode == 1 && k == 2) begin
                in_valid  = 1'b1;
                sample_in = tbl[4].x;
            end
            if (mode == 1 && k == 3) begin
                in_valid  = 1'b0;
                sample_in = tbl[2].x;
            end
            check_cycle(v, k);
            if (mode == 2 && k == 5) begin
                rst_n = 1'b0;
                break;
            end
        end
        if (mode == 2) begin
            @(negedge clk);
            rst_n   = 1'b1;
            last_y0 = 0;
            last_y1 = 0;
            check("rst mid out_valid", out_valid, 0);
            check("rst mid in_ready", in_ready, 1);
            check("rst mid busy", busy, 0);
            check("rst mid out_y0", $signed(out_y0), 0);
            check("rst mid out_idx", out_idx, 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check($sformatf("rst mid +%0d out_valid", k+1), out_valid, 0);
                check($sformatf("rst mid +%0d busy", k+1), busy, 0);
            end
        end
        if (mode == 1) begin
            for (int k = 9; k <= 12; k++) begin
                @(negedge clk);
                check_cycle(v, k);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++)
                rom[r][8*k +: 8] = 8'(coef[r][k]);

        tbl[0].x = 64'h0101_0101_0101_0101;
        tbl[0].y = '{728, -208, 0, 0, 0, 0, 0, 0};
        tbl[1].x = 64'h0000_0000_0000_0001;
        tbl[1].y = '{91, -126, 118, -106, 91, -71, 49, -25};
        tbl[2].x = 64'h8080_8080_8080_8080;
        tbl[2].y = '{-93184, 26624, 0, 0, 0, 0, 0, 0};
        tbl[3].x = 64'h7F7F_7F7F_7F7F_7F7F;
        tbl[3].y = '{92456, -26416, 0, 0, 0, 0, 0, 0};
        tbl[4].x = 64'hFF00_0000_0000_0000;
        tbl[4].y = '{-91, 82, -118, -106, -91, -71, -49, -25};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sample_in = '0;
        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset busy", busy, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset out_idx", out_idx, 0);
        check("reset out_y0", $signed(out_y0), 0);
        check("reset out_y1", $signed(out_y1), 0);
        check("reset rom_addr1", rom_addr1, 0);
        check("reset rom_addr2", rom_addr2, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset out_valid", out_valid, 0);

        for (int v = 0; v < 5; v++) run_vector(v, 0);

        // Back-to-back: in_valid held high across two vectors.
        wait_ready();
        in_valid  = 1'b1;
        sample_in = tbl[3].x;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 8) check_cycle(3, k);
            else        check_cycle(4, k - 8);
            if (k == 1) sample_in = tbl[4].x;
            if (k == 9) in_valid = 1'b0;
        end

        run_vector(1, 2);
        run_vector(2, 0);
        run_vector(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
